// File: rtl/interrupt_capture_pkg.sv
// interrupt_capture_pkg
//   Shared constants and helpers for the interrupt capture controller.
//   - REG_* : per-bank register offsets (word address bits [1:0])
//   - MAX_INTR : largest supported number of interrupt inputs
//   - bank_count() : number of 32-channel banks for a channel count
//   - bank_valid_mask() : implemented-channel mask for one bank
package interrupt_capture_pkg;

  localparam int MAX_INTR = 128;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_ENABLE = 2'd1;
  localparam logic [1:0] REG_MODE   = 2'd2;
  localparam logic [1:0] REG_RAW    = 2'd3;

  function automatic int bank_count(input int n);
    return (n + 31) / 32;
  endfunction

  // Bits of bank b that map to a real channel (only the top bank can be partial).
  function automatic logic [31:0] bank_valid_mask(input int n, input int b);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if ((32 * b + i) < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/interrupt_capture_bank.sv
// interrupt_capture_bank
//   One 32-channel slice: input sampling, edge detect, pending latch,
//   enable and mode registers, and the slice's masked-pending OR.
//   Optional macro AVS_INTR_SYNC_EN adds a two-flop synchroniser ahead of
//   the raw sample stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   irq[31:0]             interrupt sources for this slice
//   wr_status/enable/mode register write strobes (already address-decoded)
//   wdata[31:0]           write data
//   status/enable/mode/raw register contents for readback
//   irq_any               |(status & enable), combinational
module interrupt_capture_bank
  import interrupt_capture_pkg::*;
#(
  parameter logic [31:0] VALID = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] irq,
  input  logic        wr_status,
  input  logic        wr_enable,
  input  logic        wr_mode,
  input  logic [31:0] wdata,
  output logic [31:0] status,
  output logic [31:0] enable,
  output logic [31:0] mode,
  output logic [31:0] raw,
  output logic        irq_any
);

  logic [31:0] sample;
  logic [31:0] raw_d;
  logic [31:0] w1c;
  logic [31:0] rise;
  logic [31:0] status_next;

`ifdef AVS_INTR_SYNC_EN
  logic [31:0] sync_1;
  logic [31:0] sync_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= irq & VALID;
      sync_2 <= sync_1;
    end
  end

  assign sample = sync_2;
`else
  assign sample = irq & VALID;
`endif

  // Edge channels: a new rising edge beats a simultaneous W1C.
  // Level channels: W1C beats the level for one cycle, then the still-high
  // source sets the bit again.
  always_comb begin
    w1c         = wr_status ? wdata : '0;
    rise        = raw & ~raw_d;
    status_next = ((mode & (rise | (status & ~w1c))) |
                   (~mode & ~w1c & (status | raw))) & VALID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw    <= '0;
      raw_d  <= '0;
      status <= '0;
      enable <= '0;
      mode   <= '0;
    end else begin
      raw    <= sample;
      raw_d  <= raw;
      status <= status_next;
      if (wr_enable) enable <= wdata & VALID;
      if (wr_mode)   mode   <= wdata & VALID;
    end
  end

  assign irq_any = |(status & enable);

endmodule

// File: rtl/interrupt_capture_ctrl.sv
// interrupt_capture_ctrl
//   Captures NUM_INTR (1..128) interrupt inputs as level or rising-edge
//   pending bits, masks them and drives one registered aggregated IRQ.
//   Software access is an Avalon-MM slave, read latency 1, zero wait.
//   Optional macro AVS_INTR_SYNC_EN: two-flop synchroniser on every input
//   (+2 cycles input-to-pending latency).
// Ports:
//   csi_mem_clock_clock    clock
//   rsi_mem_reset_reset_n  asynchronous active-low reset
//   avs_mem_address        word address {bank, reg[1:0]}
//   avs_mem_read/readdata  read strobe / data one cycle later (0 when idle)
//   avs_mem_write/writedata write strobe / data
//   irn_interrupt_irq      interrupt sources, active-high
//   ins_irq_irq            aggregated interrupt, active-high, registered
module interrupt_capture_ctrl
  import interrupt_capture_pkg::*;
#(
  parameter  int NUM_INTR  = 32,
  localparam int NUM_BANKS = bank_count(NUM_INTR),
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ADDR_W    = 2 + BANK_W
) (
  input  logic                csi_mem_clock_clock,
  input  logic                rsi_mem_reset_reset_n,
  input  logic [ADDR_W-1:0]   avs_mem_address,
  input  logic                avs_mem_read,
  output logic [31:0]         avs_mem_readdata,
  input  logic                avs_mem_write,
  input  logic [31:0]         avs_mem_writedata,
  input  logic [NUM_INTR-1:0] irn_interrupt_irq,
  output logic                ins_irq_irq
);

  logic [BANK_W-1:0]       bank_sel;
  logic [1:0]              reg_sel;
  logic [NUM_BANKS*32-1:0] irq_pad;
  logic [31:0]             status_b [NUM_BANKS];
  logic [31:0]             enable_b [NUM_BANKS];
  logic [31:0]             mode_b   [NUM_BANKS];
  logic [31:0]             raw_b    [NUM_BANKS];
  logic [NUM_BANKS-1:0]    any_b;
  logic [31:0]             rd_mux;

  assign bank_sel = avs_mem_address[ADDR_W-1:2];
  assign reg_sel  = avs_mem_address[1:0];
  assign irq_pad  = (NUM_BANKS*32)'(irn_interrupt_irq);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [31:0] VMASK = bank_valid_mask(NUM_INTR, b);
    logic hit;

    assign hit = avs_mem_write && (bank_sel == BANK_W'(b));

    interrupt_capture_bank #(
      .VALID(VMASK)
    ) u_bank (
      .clk       (csi_mem_clock_clock),
      .rst_n     (rsi_mem_reset_reset_n),
      .irq       (irq_pad[32*b +: 32]),
      .wr_status (hit && (reg_sel == REG_STATUS)),
      .wr_enable (hit && (reg_sel == REG_ENABLE)),
      .wr_mode   (hit && (reg_sel == REG_MODE)),
      .wdata     (avs_mem_writedata),
      .status    (status_b[b]),
      .enable    (enable_b[b]),
      .mode      (mode_b[b]),
      .raw       (raw_b[b]),
      .irq_any   (any_b[b])
    );
  end

  // Unimplemented banks (address space beyond NUM_BANKS) fall through to 0.
  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel == BANK_W'(b)) begin
        case (reg_sel)
          REG_STATUS: rd_mux = status_b[b];
          REG_ENABLE: rd_mux = enable_b[b];
          REG_MODE:   rd_mux = mode_b[b];
          default:    rd_mux = raw_b[b];
        endcase
      end
    end
  end

  // rd_mux sees pre-edge register values, so a same-cycle write is not visible.
  always_ff @(posedge csi_mem_clock_clock or negedge rsi_mem_reset_reset_n) begin
    if (!rsi_mem_reset_reset_n) begin
      avs_mem_readdata <= '0;
      ins_irq_irq      <= 1'b0;
    end else begin
      avs_mem_readdata <= avs_mem_read ? rd_mux : '0;
      ins_irq_irq      <= |any_b;
    end
  end

endmodule

// File: tb/tb_interrupt_capture_ctrl.sv
module tb_interrupt_capture_ctrl;

  localparam int NI = 40;
  localparam int NB = (NI + 31) / 32;
  localparam int AW = 3;
`ifdef AVS_INTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic [31:0]   readdata;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [NI-1:0] irq = '0;
  logic          irq_out;

  int total = 0;
  int bad = 0;

  interrupt_capture_ctrl #(.NUM_INTR(NI)) dut (
    .csi_mem_clock_clock   (clk),
    .rsi_mem_reset_reset_n (rst_n),
    .avs_mem_address       (address),
    .avs_mem_read          (read),
    .avs_mem_readdata      (readdata),
    .avs_mem_write         (write),
    .avs_mem_writedata     (writedata),
    .irn_interrupt_irq     (irq),
    .ins_irq_irq           (irq_out)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel arrays plus a history of sampled inputs.
  // hist[LAT] is the value visible as RAW, hist[LAT+1] the one before it.
  logic [NI-1:0] m_pend, m_en, m_mode;
  logic [NI-1:0] hist[$];
  logic          m_irq;
  logic [31:0]   m_rd;

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_irq = 1'b0; m_rd = '0;
    hist.delete();
    for (int i = 0; i < LAT + 2; i++) hist.push_back('0);
  endtask

  function automatic logic [31:0] model_reg(input logic [AW-1:0] a);
    logic [31:0]   v;
    logic [NI-1:0] rawv;
    int            bk;
    int            c;
    v    = '0;
    rawv = hist[LAT];
    bk   = int'(a) / 4;
    for (int bit_i = 0; bit_i < 32; bit_i++) begin
      c = 32 * bk + bit_i;
      if (bk < NB && c < NI) begin
        case (int'(a) % 4)
          0: v[bit_i] = m_pend[c];
          1: v[bit_i] = m_en[c];
          2: v[bit_i] = m_mode[c];
          default: v[bit_i] = rawv[c];
        endcase
      end
    end
    return v;
  endfunction

  task automatic model_edge(input logic [NI-1:0] irq_s, input logic wr_s, input logic rd_s,
                            input logic [AW-1:0] a_s, input logic [31:0] wd_s);
    logic [NI-1:0] raw_c, rawd_c, np;
    logic          w1c;
    int            bk, rg;
    raw_c  = hist[LAT];
    rawd_c = hist[LAT+1];
    bk = int'(a_s) / 4;
    rg = int'(a_s) % 4;
    m_rd  = rd_s ? model_reg(a_s) : 32'h0;
    m_irq = |(m_pend & m_en);
    np = m_pend;
    for (int c = 0; c < NI; c++) begin
      w1c = wr_s && bk == c / 32 && rg == 0 && wd_s[c % 32];
      if (m_mode[c]) np[c] = (raw_c[c] && !rawd_c[c]) || (m_pend[c] && !w1c);
      else           np[c] = !w1c && (m_pend[c] || raw_c[c]);
    end
    m_pend = np;
    for (int c = 0; c < NI; c++) begin
      if (wr_s && bk == c / 32 && rg == 1) m_en[c]   = wd_s[c % 32];
      if (wr_s && bk == c / 32 && rg == 2) m_mode[c] = wd_s[c % 32];
    end
    hist.push_front(irq_s);
    void'(hist.pop_back());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model consumes the inputs present at the edge, DUT compared 1ns later.
  task automatic tick();
    logic [NI-1:0] irq_s;
    logic          wr_s, rd_s;
    logic [AW-1:0] a_s;
    logic [31:0]   wd_s;
    irq_s = irq; wr_s = write; rd_s = read; a_s = address; wd_s = writedata;
    @(posedge clk);
    model_edge(irq_s, wr_s, rd_s, a_s, wd_s);
    #1;
    chk("irq_model", {31'd0, irq_out}, {31'd0, m_irq});
    chk("rdata_model", readdata, m_rd);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag, input logic [31:0] exp);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    chk(tag, readdata, exp);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_irq", {31'd0, irq_out}, 32'd0);
    chk("reset_rdata", readdata, 32'd0);
    rst_n = 1'b1;

    for (int a = 0; a < 8; a++) rd(AW'(a), "reset_reg", 32'h0);

    // Level channel 0
    wr(3'd1, 32'h1);
    irq[0] = 1'b1;
    tick();
    repeat (LAT) tick();
    tick();
    chk("lvl_irq_early", {31'd0, irq_out}, 32'd0);
    tick();
    chk("lvl_irq_set", {31'd0, irq_out}, 32'd1);
    rd(3'd0, "lvl_status", 32'h1);
    wr(3'd0, 32'h1);
    rd(3'd0, "lvl_w1c_cleared", 32'h0);
    rd(3'd0, "lvl_w1c_reset", 32'h1);
    irq[0] = 1'b0;
    repeat (LAT + 2) tick();
    wr(3'd0, 32'h1);
    tick();
    chk("lvl_irq_clear", {31'd0, irq_out}, 32'd0);
    rd(3'd0, "lvl_status_clear", 32'h0);

    // Edge channel 1
    wr(3'd2, 32'h2);
    wr(3'd1, 32'h2);
    irq[1] = 1'b1;
    tick();
    irq[1] = 1'b0;
    repeat (LAT + 3) tick();
    rd(3'd0, "edge_status", 32'h2);
    repeat (3) tick();
    rd(3'd0, "edge_held", 32'h2);
    chk("edge_irq", {31'd0, irq_out}, 32'd1);
    irq[1] = 1'b1;
    tick();
    irq[1] = 1'b0;
    repeat (LAT) tick();
    wr(3'd0, 32'h2);
    rd(3'd0, "edge_set_wins", 32'h2);
    wr(3'd0, 32'h2);
    rd(3'd0, "edge_w1c", 32'h0);

    // Partial top bank
    irq[39] = 1'b1;
    wr(3'd5, 32'h80);
    repeat (LAT + 2) tick();
    rd(3'd4, "b1_status", 32'h80);
    chk("b1_irq", {31'd0, irq_out}, 32'd1);
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, "b1_enable_mask", 32'h0000_00FF);
    rd(3'd7, "b1_raw", 32'h80);
    wr(3'd7, 32'h0);
    rd(3'd7, "b1_raw_ro", 32'h80);

    // Enable gating
    wr(3'd5, 32'h0);
    tick();
    chk("mask_irq_off", {31'd0, irq_out}, 32'd0);
    wr(3'd5, 32'h80);
    chk("mask_irq_lag", {31'd0, irq_out}, 32'd0);
    tick();
    chk("mask_irq_on", {31'd0, irq_out}, 32'd1);

    // Async reset between edges
    address = 3'd5; read = 1'b1;
    tick();
    read = 1'b0;
    chk("pre_rst_rdata", readdata, 32'h80);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_irq", {31'd0, irq_out}, 32'd0);
    chk("async_rst_rdata", readdata, 32'h0);
    irq = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int a = 0; a < 8; a++) rd(AW'(a), "post_rst_reg", 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [NI-1:0] flip;
      int            op;
      flip = {8'($urandom), 32'($urandom)} & {8'($urandom), 32'($urandom)}
             & {8'($urandom), 32'($urandom)};
      irq = irq ^ flip;
      op = $urandom_range(0, 9);
      address   = AW'($urandom_range(0, 7));
      writedata = (op == 0) ? 32'hFFFF_FFFF : $urandom;
      write     = (op <= 3);
      read      = (op >= 3);
      tick();
      write = 1'b0;
      read  = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
